// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [7:0] LAST_ADDR_DEFAULT = 8'h48;
  localparam logic [7:0] WORD_BYTES        = 8'd4;

endpackage

// File: rtl/inst_fetch_queue.sv
// Two-entry {data, pc} FIFO between the ROM capture point and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
module inst_fetch_queue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic [7:0]  push_pc,
  input  logic        pop,
  input  logic        flush,
  output logic        head_valid,
  output logic [31:0] head_data,
  output logic [7:0]  head_pc,
  output logic [1:0]  count
);

  logic [31:0] data0_q, data1_q;
  logic [7:0]  pc0_q, pc1_q;
  logic [1:0]  count_q;
  logic        do_pop, do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data0_q <= 32'h0;
      data1_q <= 32'h0;
      pc0_q   <= 8'h00;
      pc1_q   <= 8'h00;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= push_data;
            pc0_q   <= push_pc;
          end else begin
            data1_q <= push_data;
            pc1_q   <= push_pc;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          data0_q <= data1_q;
          pc0_q   <= pc1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_q <= push_data;
            pc0_q   <= push_pc;
          end else begin
            data0_q <= data1_q;
            pc0_q   <= pc1_q;
            data1_q <= push_data;
            pc1_q   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = data0_q;
  assign head_pc    = pc0_q;
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: drives the registered ROM, captures words one
// cycle later, and hands them to decode with redirect, halt and fault handling.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [7:0] LAST_ADDR = LAST_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  Address,
  input  logic [31:0] InstIn,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [7:0]  inst_pc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fsm_state
);

  // Handshake: a word transfers on every cycle where inst_valid && inst_ready;
  // while inst_valid && !inst_ready the head (inst_data, inst_pc) is held.

  fetch_state_t state_q;
  logic [7:0]   pc_q, live_pc_q;
  logic         live_q, halted_q, fault_q;
  logic         pop, push, flush, issue;
  logic [1:0]   q_count;
  logic [2:0]   load, limit;

  assign pop   = inst_valid && inst_ready;
  assign flush = redirect_valid || (state_q == ST_FAULT);
  assign push  = live_q && !flush;

  // Queued plus in-flight words must leave room for the word issued now.
  assign load  = {1'b0, q_count} + {2'b00, live_q};
  assign limit = 3'd2 + {2'b00, pop};
  assign issue = (state_q == ST_RUN) && !redirect_valid &&
                 (pc_q <= LAST_ADDR) && (load < limit);

  inst_fetch_queue u_fetch_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (InstIn),
    .push_pc    (live_pc_q),
    .pop        (pop),
    .flush      (flush),
    .head_valid (inst_valid),
    .head_data  (inst_data),
    .head_pc    (inst_pc),
    .count      (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= 8'h00;
      live_q    <= 1'b0;
      live_pc_q <= 8'h00;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_HALT: begin
          if (redirect_valid) begin
            live_q <= 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
              pc_q     <= redirect_target;
              state_q  <= ST_RUN;
              halted_q <= 1'b0;
            end else begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            live_q <= issue;
            if (issue) begin
              live_pc_q <= pc_q;
              pc_q      <= pc_q + WORD_BYTES;
            end
            if ((state_q == ST_RUN) && (pc_q > LAST_ADDR)) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        default: begin
          live_q <= 1'b0;
        end
      endcase
    end
  end

  assign Address   = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: ROM model, expected-queue scoreboard with a
// handshake monitor, and cycle-exact checks of redirect, halt, fault and reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  address;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
  logic        halted;
  logic        fault;
  logic [1:0]  fsm_state;

  logic [31:0] rom_mem [0:63];
  logic [39:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          base = 0;

  inst_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Address         (address),
    .InstIn          (inst_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .halted          (halted),
    .fault           (fault),
    .fsm_state       (fsm_state)
  );

  // Clock / ROM model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) inst_in <= rom_mem[address[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'ha500_0000 | i;
    rom_mem[0]  = 32'h00450693;
    rom_mem[1]  = 32'h00100713;
    rom_mem[7]  = 32'hffc62883;
    rom_mem[8]  = 32'h01185a63;
    rom_mem[18] = 32'hfc1ff06f;
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every completed handshake must match the queue head.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual_pc=%h actual_data=%h required=none", inst_pc, inst_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {32'h0, inst_pc}, {32'h0, e[39:32]});
        chk("sb_data", {8'h0, inst_data}, {8'h0, e[31:0]});
      end
    end
  end

  // Driver tasks
  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic push_stream(input logic [7:0] from);
    for (int a = from; a <= 'h48; a += 4) exp_q.push_back({8'(a), rom_mem[a >> 2]});
  endtask

  task automatic redirect_at(input int c, input logic [7:0] target, input bit aligned);
    goto(c);
    redirect_valid = 1'b1;
    redirect_target = target;
    goto(c + 1);
    redirect_valid = 1'b0;
    exp_q.delete();
    if (aligned) push_stream(target);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_address"}, {32'h0, address}, 40'h0);
    chk({tag, "_valid"}, {39'h0, inst_valid}, 40'h0);
    chk({tag, "_data"}, {8'h0, inst_data}, 40'h0);
    chk({tag, "_pc"}, {32'h0, inst_pc}, 40'h0);
    chk({tag, "_halted"}, {39'h0, halted}, 40'h0);
    chk({tag, "_fault"}, {39'h0, fault}, 40'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    pat = 16'b1011_0110_1110_0101;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 8'h00;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values("reset");

    // Full program stream at one word per cycle, then halt
    push_stream(8'h00);
    release_reset();
    mid();
    chk("c0_address", {32'h0, address}, 40'h0);
    chk("c0_valid", {39'h0, inst_valid}, 40'h0);
    goto(2); mid();
    chk("c2_valid", {39'h0, inst_valid}, 40'h1);
    chk("c2_pc", {32'h0, inst_pc}, 40'h00);
    goto(3); mid();
    chk("c3_pc", {32'h0, inst_pc}, 40'h04);
    goto(19); mid();
    chk("c19_halted", {39'h0, halted}, 40'h0);
    goto(20); mid();
    chk("c20_pc", {32'h0, inst_pc}, 40'h48);
    chk("c20_halted", {39'h0, halted}, 40'h1);
    goto(21); mid();
    chk("post_halt_valid", {39'h0, inst_valid}, 40'h0);
    chk("stream_drained", 40'(exp_q.size()), 40'h0);

    // Redirect out of HALT
    redirect_at(24, 8'h00, 1'b1);
    mid();
    chk("hr_halted", {39'h0, halted}, 40'h0);
    chk("hr_address", {32'h0, address}, 40'h00);
    chk("hr_valid1", {39'h0, inst_valid}, 40'h0);
    goto(26); mid();
    chk("hr_valid2", {39'h0, inst_valid}, 40'h0);
    goto(27); mid();
    chk("hr_valid3", {39'h0, inst_valid}, 40'h1);
    chk("hr_pc3", {32'h0, inst_pc}, 40'h00);

    // Mid-stream redirect to 0x1c
    redirect_at(32, 8'h1c, 1'b1);
    mid();
    chk("rd_address", {32'h0, address}, 40'h1c);
    chk("rd_valid1", {39'h0, inst_valid}, 40'h0);
    goto(34); mid();
    chk("rd_valid2", {39'h0, inst_valid}, 40'h0);
    goto(35); mid();
    chk("rd_valid3", {39'h0, inst_valid}, 40'h1);
    chk("rd_pc3", {32'h0, inst_pc}, 40'h1c);
    chk("rd_data3", {8'h0, inst_data}, {8'h0, 32'hffc62883});
    goto(36); mid();
    chk("rd_pc4", {32'h0, inst_pc}, 40'h20);
    chk("rd_data4", {8'h0, inst_data}, {8'h0, 32'h01185a63});
    goto(48); mid();
    chk("rd_drained", 40'(exp_q.size()), 40'h0);
    chk("rd_halted", {39'h0, halted}, 40'h1);

    // Backpressure from reset release
    goto(50);
    rst_n = 1'b0;
    goto(52);
    exp_q.delete();
    push_stream(8'h00);
    inst_ready = 1'b0;
    release_reset();
    for (int k = 2; k <= 6; k++) begin
      goto(k); mid();
      chk("bp_valid", {39'h0, inst_valid}, 40'h1);
      chk("bp_pc", {32'h0, inst_pc}, 40'h00);
      chk("bp_data", {8'h0, inst_data}, {8'h0, 32'h00450693});
    end
    goto(7);
    inst_ready = 1'b1;
    goto(9); mid();
    chk("bp_refill_pc9", {32'h0, inst_pc}, 40'h08);
    goto(10); mid();
    chk("bp_refill_pc10", {32'h0, inst_pc}, 40'h0c);

    // Reset while a word is presented and another is in flight
    goto(12);
    rst_n = 1'b0;
    goto(13);
    exp_q.delete();
    mid();
    chk_reset_values("midreset");
    push_stream(8'h00);
    goto(14);
    release_reset();
    goto(2); mid();
    chk("restart_valid", {39'h0, inst_valid}, 40'h1);
    chk("restart_pc", {32'h0, inst_pc}, 40'h00);
    for (int k = 3; k < 70; k++) begin
      goto(k);
      inst_ready = pat[k % 16];
    end
    inst_ready = 1'b1;
    goto(75); mid();
    chk("pattern_drained", 40'(exp_q.size()), 40'h0);
    chk("pattern_halted", {39'h0, halted}, 40'h1);

    // Misaligned redirect faults; later redirects are ignored
    redirect_at(78, 8'h00, 1'b1);
    redirect_at(83, 8'h1e, 1'b0);
    mid();
    chk("flt_fault", {39'h0, fault}, 40'h1);
    chk("flt_valid", {39'h0, inst_valid}, 40'h0);
    for (int k = 85; k <= 86; k++) begin
      goto(k); mid();
      chk("flt_valid_hold", {39'h0, inst_valid}, 40'h0);
    end
    redirect_at(88, 8'h00, 1'b0);
    for (int k = 89; k <= 91; k++) begin
      mid();
      chk("flt_sticky", {39'h0, fault}, 40'h1);
      chk("flt_ignored_valid", {39'h0, inst_valid}, 40'h0);
      goto(k + 1);
    end
    goto(93);
    rst_n = 1'b0;
    goto(94); mid();
    chk("flt_cleared", {39'h0, fault}, 40'h0);
    chk("flt_reset_halted", {39'h0, halted}, 40'h0);
    push_stream(8'h00);
    release_reset();
    goto(2); mid();
    chk("final_restart_pc", {32'h0, inst_pc}, 40'h00);
    goto(25); mid();
    chk("final_drained", 40'(exp_q.size()), 40'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
